power_emulator_core: RTL and testbench
======================================

Name: power_emulator_core

Overview:
- Synthetic power-activity emulator.
- Each cycle, a 13-bit pseudo-random activity vector selects which clock-gated elements (CGEs) are active.
- The constant power weights of the active CGEs are summed by a pipelined carry-save adder tree and a final carry-propagate adder (CPA).
- Sits behind the register-file bus wrapper, which drives start/fin from a control register and samples result into readable registers.

Parameters:
- BITS, 32, width of each per-CGE power weight.
- CGES, 13, number of clock-gated elements (operands summed).
- MAX (localparam), $clog2(CGES)+BITS = 36, result width; sum of CGES full-scale weights never overflows.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  level; run the emulation while high.
- fin  input  1  level; freeze (hold) the emulation while high; priority over start.
- result  output  MAX  registered sum of weights of the active CGEs.

Behaviour:
- Weights: W_i = (2^BITS − 1) − i, for i = 0..CGES−1. These are constants, not programmable.
- Activity LFSR:
  - CGES-bit Fibonacci LFSR, seed all ones.
  - Step: shift left; bit0 = lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0] (CGES=13 taps, defined in the package).
  - Never reaches zero.
- FSM states and transitions:
  - IDLE:
    - LFSR held at seed.
    - Operands forced to 0.
    - IDLE -> RUN when start=1 and fin=0.
  - RUN:
    - Operand i = W_i if lfsr[i], else 0.
    - LFSR steps every cycle.
    - RUN -> HOLD when fin=1.
    - RUN -> IDLE when start=0.
  - HOLD:
    - LFSR and all pipeline registers stall.
    - result holds its value.
    - HOLD -> RUN when fin=0 and start=1.
    - HOLD -> IDLE when fin=0 and start=0.
- Pipeline, 3 registered stages:
  - (1) masked operand register.
  - (2) 3:2 compressor tree producing vs/vc, both MAX wide.
  - (3) CPA: result <= vs + vc, truncated to MAX bits.
- Latency:
  - The activity vector present in the first RUN cycle appears on result 3 cycles later.
  - Thereafter result updates every cycle.
- In IDLE, zero operands flush the pipeline; result reaches 0 three cycles after entering IDLE.
- Reset (synchronous, reset_n=0):
  - state=IDLE, LFSR=seed, all pipeline registers and result = 0.
  - Reset asserted mid-RUN or mid-HOLD takes effect at the next edge and discards in-flight sums.
- Simultaneous start=1 and fin=1 from IDLE: stay in IDLE.
- Arithmetic is unsigned. The carry-save invariant vs+vc = Σ operands (mod 2^MAX) holds at stage 2.

Optional Feature:
- Macro CPA_KOGGE_STONE_EN.
- Defined: the stage-3 CPA is a structural Kogge-Stone parallel-prefix adder of MAX bits (log2 levels of generate/propagate).
- Undefined: the CPA is the behavioural "+" operator.
- result values and latency are identical in both builds.

Decomposition:
- Package power_emulator_pkg holds:
  - default BITS/CGES.
  - the MAX computation function.
  - LFSR seed and tap mask.
  - weight function W(i).
  - FSM state enum (IDLE/RUN/HOLD).
- One sub-module, pe_cpa (MAX-wide two-operand adder). It contains the CPA_KOGGE_STONE_EN variant switch.
- The compressor tree is generated inline.

Test Plan:
- Reset, then start=1, fin=0 -> 3 cycles after RUN entry, result = 0xC_FFFF_FFA5 (all 13 active); next cycle 0xB_FFFF_FFA6 (LFSR 0x1FFE, CGE0 inactive).
- fin=1 during RUN -> result frozen at its current value for every held cycle. Release fin with start=1 -> sequence resumes with the next LFSR value, no skipped or repeated vector.
- start=0 from RUN -> result becomes 0 three cycles later. Restarting replays 0xC_FFFF_FFA5 first (LFSR reseeded).
- start=1 and fin=1 asserted together from IDLE -> result stays 0, LFSR stays at seed.
- reset_n=0 mid-RUN for one cycle -> result = 0 next edge. Then the run restarts from seed as in test 1.
- Run 10,000 cycles in both macro builds -> result matches a reference model of Σ W_i·lfsr[i], delayed 3 cycles, every cycle.

Source files
------------

// File: rtl/power_emulator_pkg.sv
// rtl/power_emulator_pkg.sv - shared constants, helpers and FSM states for the power emulator
package power_emulator_pkg;

  localparam int BITS_DEF = 32;
  localparam int CGES_DEF = 13;

  // 13-bit activity LFSR: seed all ones, feedback from bits 12, 3, 2, 0.
  localparam logic [12:0] LFSR_SEED = 13'h1FFF;
  localparam logic [12:0] LFSR_TAPS = 13'h100D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pe_state_e;

  function automatic int max_width(input int bits, input int cges);
    return $clog2(cges) + bits;
  endfunction

  // CGE i weighs full scale minus its index.
  function automatic logic [63:0] weight(input int bits, input int i);
    logic [63:0] full;
    full = (64'd1 << bits) - 64'd1;
    return full - 64'(i);
  endfunction

endpackage

// File: rtl/pe_cpa.sv
// rtl/pe_cpa.sv - two-operand carry-propagate adder for the emulator result stage
// CPA_KOGGE_STONE_EN selects a Kogge-Stone prefix network; otherwise the "+" operator is used.
module pe_cpa #(
  parameter int W = 36
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

`ifdef CPA_KOGGE_STONE_EN
  localparam int LVLS = $clog2(W);

  logic [W-1:0] gk, pk, gn, pn;

  always_comb begin
    gk = a & b;
    pk = a ^ b;
    gn = '0;
    pn = '0;
    // Each level doubles the span of the group generate/propagate terms.
    for (int l = 0; l < LVLS; l++) begin
      gn = gk;
      pn = pk;
      for (int i = (1 << l); i < W; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-(1<<l)]);
        pn[i] = pk[i] & pk[i-(1<<l)];
      end
      gk = gn;
      pk = pn;
    end
    sum = (a ^ b) ^ {gk[W-2:0], 1'b0};
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/power_emulator_core.sv
// rtl/power_emulator_core.sv - LFSR-driven CGE activity summed by a 3-stage CSA/CPA pipeline
module power_emulator_core
  import power_emulator_pkg::*;
#(
  parameter  int BITS = BITS_DEF,
  parameter  int CGES = CGES_DEF,
  localparam int MAX  = max_width(BITS, CGES)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           fin,
  output logic [MAX-1:0] result
);

  localparam logic [CGES-1:0] SEED = CGES'(LFSR_SEED);
  localparam logic [CGES-1:0] TAPS = CGES'(LFSR_TAPS);
  localparam int ROWS = CGES + 2;

  pe_state_e       state_q, state_d;
  logic [CGES-1:0] lfsr_q, lfsr_d;
  logic [BITS-1:0] op_q [CGES];
  logic [BITS-1:0] op_d [CGES];
  logic [MAX-1:0]  vs_q, vs_d, vc_q, vc_d;
  logic [MAX-1:0]  result_q, result_d, cpa_sum;
  logic [MAX-1:0]  row  [ROWS];
  logic [MAX-1:0]  nrow [ROWS];
  logic            stall;

  assign stall = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !fin) state_d = RUN;
      RUN: begin
        if (fin) state_d = HOLD;
        else if (!start) state_d = IDLE;
      end
      HOLD: if (!fin) state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d = lfsr_q;
    for (int i = 0; i < CGES; i++) op_d[i] = op_q[i];
    case (state_q)
      IDLE: begin
        lfsr_d = SEED;
        for (int i = 0; i < CGES; i++) op_d[i] = '0;
      end
      RUN: begin
        lfsr_d = {lfsr_q[CGES-2:0], ^(lfsr_q & TAPS)};
        for (int i = 0; i < CGES; i++) op_d[i] = lfsr_q[i] ? BITS'(weight(BITS, i)) : '0;
      end
      default: ;
    endcase
  end

  // Wallace-style reduction: each level turns groups of three rows into sum/carry rows.
  always_comb begin
    int cnt;
    int ncnt;
    for (int i = 0; i < ROWS; i++) row[i] = '0;
    for (int i = 0; i < CGES; i++) row[i] = MAX'(op_q[i]);
    nrow = row;
    cnt  = CGES;
    ncnt = CGES;
    for (int lvl = 0; lvl < CGES; lvl++) begin
      if (cnt > 2) begin
        ncnt = 0;
        for (int g = 0; g < CGES; g += 3) begin
          if (g + 2 < cnt) begin
            nrow[ncnt]   = row[g] ^ row[g+1] ^ row[g+2];
            nrow[ncnt+1] = ((row[g] & row[g+1]) | (row[g] & row[g+2]) | (row[g+1] & row[g+2])) << 1;
            ncnt += 2;
          end else if (g < cnt) begin
            nrow[ncnt] = row[g];
            ncnt += 1;
            if (g + 1 < cnt) begin
              nrow[ncnt] = row[g+1];
              ncnt += 1;
            end
          end
        end
        row = nrow;
        cnt = ncnt;
      end
    end
    vs_d = stall ? vs_q : row[0];
    vc_d = stall ? vc_q : ((cnt > 1) ? row[1] : '0);
  end

  pe_cpa #(.W(MAX)) u_cpa (
    .a   (vs_q),
    .b   (vc_q),
    .sum (cpa_sum)
  );

  assign result_d = stall ? result_q : cpa_sum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      vs_q     <= '0;
      vc_q     <= '0;
      result_q <= '0;
      for (int i = 0; i < CGES; i++) op_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      vs_q     <= vs_d;
      vc_q     <= vc_d;
      result_q <= result_d;
      for (int i = 0; i < CGES; i++) op_q[i] <= op_d[i];
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_power_emulator_core.sv
// tb/tb_power_emulator_core.sv - directed self-checking bench for power_emulator_core
module tb_power_emulator_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        fin;
  logic [35:0] result;

  int passed = 0;
  int total  = 0;

  // Hand-computed sums for the first six activity vectors from seed.
  localparam logic [35:0] S0 = 36'hC_FFFF_FFA5;  // 0x1FFF
  localparam logic [35:0] S1 = 36'hB_FFFF_FFA6;  // 0x1FFE
  localparam logic [35:0] S2 = 36'hB_FFFF_FFA7;  // 0x1FFD
  localparam logic [35:0] S3 = 36'hA_FFFF_FFA9;  // 0x1FFA
  localparam logic [35:0] S4 = 36'h9_FFFF_FFAC;  // 0x1FF4
  localparam logic [35:0] S5 = 36'h8_FFFF_FFB0;  // 0x1FE8

  always #5 clk = ~clk;

  power_emulator_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .fin     (fin),
    .result  (result)
  );

  function automatic logic [12:0] lfsr_step(input logic [12:0] v);
    return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
  endfunction

  function automatic logic [35:0] wsum(input logic [12:0] v);
    logic [35:0] s;
    s = '0;
    for (int i = 0; i < 13; i++)
      if (v[i]) s = s + (36'h0_FFFF_FFFF - 36'(i));
    return s;
  endfunction

  function automatic logic [35:0] s_nth(input int n);
    logic [12:0] v;
    v = 13'h1FFF;
    for (int k = 0; k < n; k++) v = lfsr_step(v);
    return wsum(v);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    fin     = 1'b0;
    cyc(3);
    total++;
    if (result !== 36'd0) $display("FAIL reset_held: got %h expected %h", result, 36'd0);
    else passed++;
    reset_n = 1'b1;
    cyc(2);
    total++;
    if (result !== 36'd0) $display("FAIL reset_idle: got %h expected %h", result, 36'd0);
    else passed++;
  endtask

  task automatic test_run;
    start = 1'b1;
    cyc(3);
    total++;
    if (result !== 36'd0) $display("FAIL run_latency: got %h expected %h", result, 36'd0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S0) $display("FAIL run_s0: got %h expected %h", result, S0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S1) $display("FAIL run_s1: got %h expected %h", result, S1);
    else passed++;
    cyc(1);
    total++;
    if (result !== S2) $display("FAIL run_s2: got %h expected %h", result, S2);
    else passed++;
  endtask

  task automatic test_hold;
    fin = 1'b1;
    cyc(1);
    total++;
    if (result !== S3) $display("FAIL hold_enter: got %h expected %h", result, S3);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      total++;
      if (result !== S3) $display("FAIL hold_frozen%0d: got %h expected %h", k, result, S3);
      else passed++;
    end
    fin = 1'b0;
    cyc(1);
    total++;
    if (result !== S3) $display("FAIL hold_release: got %h expected %h", result, S3);
    else passed++;
    cyc(1);
    total++;
    if (result !== S4) $display("FAIL hold_resume_s4: got %h expected %h", result, S4);
    else passed++;
    cyc(1);
    total++;
    if (result !== S5) $display("FAIL hold_resume_s5: got %h expected %h", result, S5);
    else passed++;
  endtask

  task automatic test_stop;
    start = 1'b0;
    for (int k = 6; k <= 8; k++) begin
      cyc(1);
      total++;
      if (result !== s_nth(k)) $display("FAIL stop_drain%0d: got %h expected %h", k, result, s_nth(k));
      else passed++;
    end
    cyc(1);
    total++;
    if (result !== 36'd0) $display("FAIL stop_zero: got %h expected %h", result, 36'd0);
    else passed++;
    cyc(2);
    start = 1'b1;
    cyc(3);
    total++;
    if (result !== 36'd0) $display("FAIL restart_latency: got %h expected %h", result, 36'd0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S0) $display("FAIL restart_s0: got %h expected %h", result, S0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S1) $display("FAIL restart_s1: got %h expected %h", result, S1);
    else passed++;
  endtask

  task automatic test_start_fin_idle;
    start = 1'b0;
    cyc(5);
    start = 1'b1;
    fin   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      total++;
      if (result !== 36'd0) $display("FAIL both_idle%0d: got %h expected %h", k, result, 36'd0);
      else passed++;
    end
    fin = 1'b0;
    cyc(3);
    total++;
    if (result !== 36'd0) $display("FAIL both_latency: got %h expected %h", result, 36'd0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S0) $display("FAIL both_seed_s0: got %h expected %h", result, S0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S1) $display("FAIL both_seed_s1: got %h expected %h", result, S1);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    reset_n = 1'b0;
    cyc(1);
    total++;
    if (result !== 36'd0) $display("FAIL midrst_zero: got %h expected %h", result, 36'd0);
    else passed++;
    reset_n = 1'b1;
    cyc(3);
    total++;
    if (result !== 36'd0) $display("FAIL midrst_latency: got %h expected %h", result, 36'd0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S0) $display("FAIL midrst_s0: got %h expected %h", result, S0);
    else passed++;
    cyc(1);
    total++;
    if (result !== S1) $display("FAIL midrst_s1: got %h expected %h", result, S1);
    else passed++;
  endtask

  task automatic test_hold_to_idle;
    fin = 1'b1;
    cyc(1);
    total++;
    if (result !== S2) $display("FAIL h2i_enter: got %h expected %h", result, S2);
    else passed++;
    start = 1'b0;
    cyc(2);
    total++;
    if (result !== S2) $display("FAIL h2i_frozen: got %h expected %h", result, S2);
    else passed++;
    fin = 1'b0;
    cyc(1);
    total++;
    if (result !== S2) $display("FAIL h2i_exit: got %h expected %h", result, S2);
    else passed++;
    cyc(1);
    total++;
    if (result !== S3) $display("FAIL h2i_drain_s3: got %h expected %h", result, S3);
    else passed++;
    cyc(1);
    total++;
    if (result !== S4) $display("FAIL h2i_drain_s4: got %h expected %h", result, S4);
    else passed++;
    cyc(1);
    total++;
    if (result !== 36'd0) $display("FAIL h2i_zero: got %h expected %h", result, 36'd0);
    else passed++;
  endtask

  task automatic test_long_run;
    logic [12:0] v;
    logic [35:0] exp_r;
    start = 1'b0;
    fin   = 1'b0;
    cyc(5);
    start = 1'b1;
    v = 13'h1FFF;
    cyc(3);
    total++;
    if (result !== 36'd0) $display("FAIL long_latency: got %h expected %h", result, 36'd0);
    else passed++;
    for (int j = 0; j < 10000; j++) begin
      cyc(1);
      exp_r = wsum(v);
      total++;
      if (result !== exp_r) $display("FAIL long_cycle%0d: got %h expected %h", j, result, exp_r);
      else passed++;
      v = lfsr_step(v);
    end
    start = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_run();
    test_hold();
    test_stop();
    test_start_fin_idle();
    test_reset_mid_run();
    test_hold_to_idle();
    test_long_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
